mavg_div_seq: RTL and testbench

//  Sequential signed moving-average engine. Keeps the last WIN samples in a ring buffer and a

---
 rtl/mavg_div_seq.sv | 138 +++++++++++++
 tb/tb_mavg_div_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mavg_div_seq.sv
// Signed moving average over the last WIN samples, divided by the current fill count.
// Latency: accepting edge E0 -> out_valid after edge E0+NB+2.
// Backpressure: one sample in flight; in_ready only in IDLE; the result is held until out_ready.
module mavg_div_seq #(
    parameter int DW   = 8,
    parameter int WIN  = 5,
    parameter int FRAC = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_sample,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW+FRAC-1:0]         avg,
    output logic [$clog2(WIN+1)-1:0]   count
);
    localparam int SW = DW + $clog2(WIN);
    localparam int NB = SW + FRAC;
    localparam int AW = DW + FRAC;
    localparam int CW = $clog2(WIN + 1);
    localparam int PW = $clog2(WIN);
    localparam int IW = $clog2(NB + 1);
    localparam logic [IW-1:0] LAST_IT = IW'(NB);

    typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

    state_t                state, state_nx;
    logic signed [DW-1:0]  ring [WIN];
    logic [PW-1:0]         wr_ptr;
    logic signed [DW-1:0]  new_s, ev_s;
    logic signed [SW-1:0]  sum, sum_nx;
    logic [SW-1:0]         mag;
    logic [NB-1:0]         dq;
    logic [CW-1:0]         rem, rem_nx;
    logic [CW:0]           trial, diff;
    logic                  ge;
    logic [IW-1:0]         itr;
    logic                  sign;
    logic [AW-1:0]         q_fin, avg_nx;
    logic                  accept;

    // A sample is taken only in IDLE and never in the same cycle as a flush.
    assign accept = in_valid && in_ready && !clear;

    // Running sum with the new sample added and the evicted one removed.
    assign sum_nx = sum + SW'(new_s) - SW'(ev_s);
    assign mag    = sum_nx[SW-1] ? SW'(-sum_nx) : SW'(sum_nx);

    // One restoring step: shift in the next dividend bit, subtract the count if it fits.
    assign trial  = {rem, dq[NB-1]};
    assign diff   = trial - {1'b0, count};
    assign ge     = (trial >= {1'b0, count});
    assign rem_nx = ge ? diff[CW-1:0] : trial[CW-1:0];

    // Quotient is a magnitude; reapply the sign of the sum.
    assign q_fin  = dq[AW-1:0];
    assign avg_nx = sign ? AW'(-q_fin) : q_fin;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; a flush returns to IDLE from anywhere.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ACCUM;
            ACCUM:   state_nx = DIV;
            DIV:     if (itr == LAST_IT) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Window, running sum, divider and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) ring[i] <= '0;
            wr_ptr <= '0;
            new_s  <= '0;
            ev_s   <= '0;
            sum    <= '0;
            count  <= '0;
            dq     <= '0;
            rem    <= '0;
            itr    <= '0;
            sign   <= 1'b0;
            avg    <= '0;
        end else if (clear) begin
            for (int i = 0; i < WIN; i++) ring[i] <= '0;
            wr_ptr <= '0;
            new_s  <= '0;
            ev_s   <= '0;
            sum    <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    // Capture the outgoing sample before overwriting its slot.
                    new_s        <= in_sample;
                    ev_s         <= (count == CW'(WIN)) ? ring[wr_ptr] : '0;
                    ring[wr_ptr] <= in_sample;
                    wr_ptr       <= (wr_ptr == PW'(WIN - 1)) ? '0 : wr_ptr + PW'(1);
                end
                ACCUM: begin
                    sum   <= sum_nx;
                    count <= (count == CW'(WIN)) ? count : count + CW'(1);
                    dq    <= {mag, FRAC'(0)};
                    rem   <= '0;
                    sign  <= sum_nx[SW-1];
                    itr   <= '0;
                end
                DIV: begin
                    if (itr == LAST_IT) begin
                        avg <= avg_nx;
                    end else begin
                        rem <= rem_nx;
                        dq  <= {dq[NB-2:0], ge};
                        itr <= itr + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mavg_div_seq.sv
module tb_mavg_div_seq;
    localparam int DW   = 8;
    localparam int WIN  = 5;
    localparam int FRAC = 4;
    localparam int AW   = DW + FRAC;
    localparam int CW   = $clog2(WIN + 1);
    localparam int LAT  = DW + $clog2(WIN) + FRAC + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_sample = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] avg;
    logic [CW-1:0] count;

    int n_chk  = 0;
    int n_fail = 0;
    int win_q[$];

    mavg_div_seq #(.DW(DW), .WIN(WIN), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .out_valid(out_valid), .out_ready(out_ready),
        .avg(avg), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: keep the last WIN samples, average = sum*2^FRAC/n truncated toward zero.
    function automatic logic [31:0] model_avg();
        int s = 0;
        int q;
        logic [31:0] r;
        foreach (win_q[i]) s += win_q[i];
        q = (s * (1 << FRAC)) / win_q.size();
        r = q;
        return {20'd0, r[AW-1:0]};
    endfunction

    function automatic logic [31:0] model_cnt();
        return win_q.size();
    endfunction

    task automatic model_push(input int s);
        int dropped;
        win_q.push_back(s);
        if (win_q.size() > WIN) dropped = win_q.pop_front();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        win_q.delete();
    endtask

    // Offer one sample, wait for the result, compare, then handshake it out.
    task automatic run_sample(input int s, input string tag);
        int lat;
        check({tag, "_in_ready"}, in_ready, 1);
        in_sample = s[DW-1:0];
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_push(s);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_avg"}, avg, model_avg());
        check({tag, "_count"}, count, model_cnt());
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        logic [AW-1:0] held;
        int s;

        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_avg", avg, 0);
        check("rst_count", count, 0);

        // Reset pulse in the middle of a division.
        in_sample = 8'd50; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_avg", avg, 0);
        check("midrst_count", count, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 1);
        repeat (20) begin @(posedge clk); #1; end
        check("midrst_no_result", out_valid, 0);
        check("midrst_count_after", count, 0);

        // Single sample into an empty window.
        run_sample(10, "s10");
        check("s10_const", avg, 12'h0A0);

        // Three samples.
        do_clear();
        run_sample(10, "t3a"); run_sample(20, "t3b"); run_sample(3, "t3c");
        check("t3_const", avg, 12'h0B0);

        // Window saturation.
        do_clear();
        for (int i = 1; i <= 7; i++) run_sample(i, "sat");
        check("sat_const", avg, 12'h050);
        check("sat_count", count, WIN);

        // Negative truncation toward zero, then the most negative average.
        do_clear();
        run_sample(-5, "neg"); run_sample(0, "neg"); run_sample(0, "neg");
        check("neg_const", avg, 12'hFE6);
        do_clear();
        for (int i = 0; i < 5; i++) run_sample(-128, "min");
        check("min_const", avg, 12'h800);

        // Stall the consumer and check the result is held.
        in_sample = 8'd33; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        model_push(33);
        repeat (LAT) begin @(posedge clk); #1; end
        check("hold_valid_start", out_valid, 1);
        held = avg;
        check("hold_avg_val", avg, model_avg());
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_avg", avg, held);
            check("hold_in_ready", in_ready, 0);
        end
        // Flush with a sample offered, in DONE and again in IDLE: nothing is accepted.
        clear = 1'b1; in_valid = 1'b1; in_sample = 8'd99;
        @(posedge clk); #1;
        check("clr_valid", out_valid, 0);
        check("clr_avg_kept", avg, held);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        win_q.delete();
        check("clr_count", count, 0);
        repeat (25) begin @(posedge clk); #1; end
        check("clr_dropped", out_valid, 0);
        check("clr_count_after", count, 0);
        run_sample(7, "post_clr");

        // Randomized run with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) do_clear();
            s = $urandom_range(0, 255);
            if (s > 127) s -= 256;
            run_sample(s, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
